// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: the FSM state enum, a clog2 helper for the select width, and the default beat limit per grant.
package mux_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEFAULT_MAX_HOLD = 4;

    // Select width for n requesters; never below one bit.
    function automatic int clog2_n(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
// Ports: req[N] request vector, ptr start index; found = any request set, idx = chosen index.
module rr_pick
    import mux_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2_n(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    // One extra bit so ptr + k never overflows before the modulo-N fold.
    localparam logic [PW:0] N_EXT = (PW+1)'(N);

    logic [PW:0] cand;

    // Walk the candidates from farthest to nearest so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (req[cand[PW-1:0]]) begin
                found = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter driving a shared W-bit mux to one valid/ready consumer.
// Latency: grant registered one edge after req is seen in IDLE; one IDLE bubble between grants.
// Backpressure: out_ready low stalls the beat; out_valid and data_out hold, beat count holds.
// Ports: clk, rst_n (sync, active-low), req[N], data_in[N*W], out_ready in;
//        gnt[N] (one-hot), sel, data_out[W], out_valid out.
// Optional: MUX_ARBITER_LOCK_EN adds lock[N]; while lock[sel] is high the MAX_HOLD
//           release is suppressed and only a dropped request ends the grant.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        data_in,
`ifdef MUX_ARBITER_LOCK_EN
    input  logic [N-1:0]          lock,
`endif
    input  logic                  out_ready,
    output logic [N-1:0]          gnt,
    output logic [clog2_n(N)-1:0] sel,
    output logic [W-1:0]          data_out,
    output logic                  out_valid
);

    localparam int            SW        = clog2_n(N);
    localparam logic [7:0]    LAST_BEAT = 8'(MAX_HOLD - 1);
    localparam logic [SW-1:0] LAST_IDX  = SW'(N - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          pick_found;
    logic [SW-1:0] pick_idx;
    logic          beat;
    logic          locked;
    logic          release_now;
    logic [W-1:0]  words [N];

    for (genvar i = 0; i < N; i++) begin : g_words
        assign words[i] = data_in[i*W +: W];
    end

    rr_pick #(
        .N  (N),
        .PW (SW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef MUX_ARBITER_LOCK_EN
    assign locked = lock[sel_q];
`else
    assign locked = 1'b0;
`endif

    // Valid follows the live request of the granted requester, so a dropped
    // request stops beats immediately, before the registered release.
    assign out_valid = (state_q == GRANT) && req[sel_q];
    assign data_out  = out_valid ? words[sel_q] : '0;
    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign beat      = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    gnt_d   = N'(1) << pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Saturate at the last beat index; only the locked case ever sits there.
                if (beat && (cnt_q != LAST_BEAT)) begin
                    cnt_d = cnt_q + 8'd1;
                end
                release_now = !req[sel_q] || (beat && (cnt_q == LAST_BEAT) && !locked);
                if (release_now) begin
                    gnt_d   = '0;
                    // The departing requester becomes lowest priority next time.
                    ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + SW'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter (N=4, W=32, MAX_HOLD=4).
// Latency: n/a (testbench).
// Backpressure: drives out_ready randomly and in directed stall windows.
module tb_mux_arbiter;
    import mux_arbiter_pkg::*;

    localparam int N        = 4;
    localparam int W        = 32;
    localparam int MAX_HOLD = 4;
    localparam int SW       = clog2_n(N);
    localparam int OBS_W    = N + SW + 1 + W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic           out_ready;
    logic [N-1:0]   gnt;
    logic [SW-1:0]  sel;
    logic [W-1:0]   data_out;
    logic           out_valid;
`ifdef MUX_ARBITER_LOCK_EN
    logic [N-1:0]   lock_s;
`endif

    wire [OBS_W-1:0] obs = {gnt, sel, out_valid, data_out};

    int nvec = 0;
    int nerr = 0;

    // Reference model: who holds the grant, priority pointer, beats taken so far.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    mux_arbiter #(
        .N        (N),
        .W        (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
`ifdef MUX_ARBITER_LOCK_EN
        .lock      (lock_s),
`endif
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    function automatic logic [W-1:0] word(input int i);
        return W'(data_in >> (i * W));
    endfunction

    function automatic logic [OBS_W-1:0] expected();
        logic [N-1:0] g;
        logic         v;
        logic [W-1:0] d;
        g = m_busy ? (N'(1) << m_owner) : '0;
        v = m_busy && req[SW'(m_owner)];
        d = v ? word(m_owner) : '0;
        return {g, SW'(m_owner), v, d};
    endfunction

    // Advance the model by one clock edge using the inputs as they stand at the edge.
    task automatic model_edge();
        bit locked;
        locked = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            return;
        end
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (req[SW'(i)]) begin
                    m_busy = 1'b1; m_owner = i; m_cnt = 0;
                    break;
                end
            end
        end else begin
`ifdef MUX_ARBITER_LOCK_EN
            locked = lock_s[SW'(m_owner)];
`endif
            if (!req[SW'(m_owner)]) begin
                m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
            end else if (out_ready) begin
                if (m_cnt < MAX_HOLD - 1) begin
                    m_cnt++;
                end else if (!locked) begin
                    m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
                end
            end
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) begin
            data_in = {data_in[N*W-W-1:0], W'($urandom())};
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; out_ready = 1'b1;
        clk_edge();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '1; out_ready = 1'b1;
        randomize_data();
        for (int c = 0; c < 2; c++) begin
            clk_edge();
            @(negedge clk);
            nvec++;
            if (gnt !== '0 || out_valid !== 1'b0 || data_out !== '0) begin
                nerr++;
                $display("FAIL reset_outputs cyc %0d: gnt=%b vld=%b dat=%h, want 0 0 0", c, gnt, out_valid, data_out);
            end
        end
        rst_n = 1'b1;
        clk_edge();
        @(negedge clk);
        nvec++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            nerr++;
            $display("FAIL reset_first_grant: gnt=%b sel=%0d, want 0001 0", gnt, sel);
        end
        nvec++;
        if (obs !== expected()) begin
            nerr++;
            $display("FAIL reset_model: got %h want %h", obs, expected());
        end
    endtask

    task automatic test_single();
        logic [10:0] pat;
        pat = '0;
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 11; c++) begin
            randomize_data();
            @(negedge clk);
            pat = {out_valid, pat[10:1]};
            nvec++;
            if (obs !== expected()) begin
                nerr++;
                $display("FAIL single_model cyc %0d: got %h want %h", c, obs, expected());
            end
            if (c == 1) begin
                nvec++;
                if (gnt !== 4'b0100 || sel !== 2'd2) begin
                    nerr++;
                    $display("FAIL single_grant: gnt=%b sel=%0d, want 0100 2", gnt, sel);
                end
            end
            clk_edge();
        end
        nvec++;
        if (pat !== 11'b01111011110) begin
            nerr++;
            $display("FAIL single_valid_pattern: got %b want 01111011110", pat);
        end
    endtask

    task automatic test_round_robin();
        int owners[$];
        do_reset();
        req = '1;
        for (int c = 0; c < 26; c++) begin
            randomize_data();
            @(negedge clk);
            nvec++;
            if (obs !== expected()) begin
                nerr++;
                $display("FAIL rr_model cyc %0d: got %h want %h", c, obs, expected());
            end
            if (out_valid && out_ready) owners.push_back(int'(sel));
            clk_edge();
        end
        nvec++;
        if (owners.size() != 20) begin
            nerr++;
            $display("FAIL rr_beat_count: got %0d want 20", owners.size());
        end
        for (int i = 0; i < owners.size() && i < 20; i++) begin
            nvec++;
            if (owners[i] != (i / 4) % 4) begin
                nerr++;
                $display("FAIL rr_order beat %0d: got %0d want %0d", i, owners[i], (i / 4) % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w1;
        int beats;
        beats = 0;
        do_reset();
        randomize_data();
        w1  = word(1);
        req = 4'b0010;
        for (int c = 0; c < 9; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            nvec++;
            if (obs !== expected()) begin
                nerr++;
                $display("FAIL bp_model cyc %0d: got %h want %h", c, obs, expected());
            end
            if (!out_ready) begin
                nvec++;
                if (out_valid !== 1'b1 || data_out !== w1) begin
                    nerr++;
                    $display("FAIL bp_stall cyc %0d: vld=%b dat=%h, want 1 %h", c, out_valid, data_out, w1);
                end
            end
            if (out_valid && out_ready) beats++;
            if (c == 8) begin
                nvec++;
                if (gnt !== '0 || beats != 4) begin
                    nerr++;
                    $display("FAIL bp_total: gnt=%b beats=%0d, want 0000 4", gnt, beats);
                end
            end
            clk_edge();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_early_drop();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            randomize_data();
            rst_n = (c == 6) ? 1'b0 : 1'b1;
            if (c <= 2)      req = 4'b0010;
            else if (c <= 6) req = 4'b1101;
            else             req = 4'b1111;
            @(negedge clk);
            nvec++;
            if (obs !== expected()) begin
                nerr++;
                $display("FAIL drop_model cyc %0d: got %h want %h", c, obs, expected());
            end
            if (c == 5) begin
                nvec++;
                if (gnt !== 4'b0100 || sel !== 2'd2 || out_valid !== 1'b1) begin
                    nerr++;
                    $display("FAIL drop_regrant: gnt=%b sel=%0d vld=%b, want 0100 2 1", gnt, sel, out_valid);
                end
            end
            if (c == 7) begin
                nvec++;
                if (gnt !== '0 || sel !== '0 || out_valid !== 1'b0 || data_out !== '0) begin
                    nerr++;
                    $display("FAIL midgrant_reset: gnt=%b sel=%0d vld=%b dat=%h, want 0 0 0 0", gnt, sel, out_valid, data_out);
                end
            end
            if (c == 8) begin
                nvec++;
                if (gnt !== 4'b0001) begin
                    nerr++;
                    $display("FAIL reset_ptr_grant: gnt=%b, want 0001", gnt);
                end
            end
            clk_edge();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            randomize_data();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) req = req ^ (N'(1) << i);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            nvec++;
            if (obs !== expected()) begin
                nerr++;
                $display("FAIL random_model cyc %0d: got %h want %h", c, obs, expected());
            end
            clk_edge();
        end
        out_ready = 1'b1;
    endtask

`ifdef MUX_ARBITER_LOCK_EN
    task automatic test_lock();
        int beats;
        beats = 0;
        do_reset();
        lock_s = 4'b0001;
        for (int c = 0; c < 13; c++) begin
            randomize_data();
            req = (c <= 10) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            nvec++;
            if (obs !== expected()) begin
                nerr++;
                $display("FAIL lock_model cyc %0d: got %h want %h", c, obs, expected());
            end
            if (out_valid && out_ready) beats++;
            if (c >= 1 && c <= 10) begin
                nvec++;
                if (gnt !== 4'b0001 || out_valid !== 1'b1) begin
                    nerr++;
                    $display("FAIL lock_hold cyc %0d: gnt=%b vld=%b, want 0001 1", c, gnt, out_valid);
                end
            end
            if (c == 12) begin
                nvec++;
                if (gnt !== '0 || beats != 10) begin
                    nerr++;
                    $display("FAIL lock_release: gnt=%b beats=%0d, want 0000 10", gnt, beats);
                end
            end
            clk_edge();
        end
        lock_s = '0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        data_in   = '0;
`ifdef MUX_ARBITER_LOCK_EN
        lock_s    = '0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_drop();
        test_random();
`ifdef MUX_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
